// File: rtl/pe_border_os_if.sv
// Operand, control and result bundle of one border PE.
// No valid/ready handshake: every input is sampled on each rising edge and the array controller owns all sequencing.
interface pe_border_os_if #(
    parameter int IWIDTH = 8,
    parameter int OWIDTH = 24
);
    logic              mode;
    logic              sgn;
    logic              en_i, clr_i, en_w, clr_w, en_o, clr_o, ld_o, sh_o;
    logic [IWIDTH-1:0] ifm;
    logic [IWIDTH-1:0] wght;
    logic [OWIDTH-1:0] ofm;

    logic              en_i_d, clr_i_d, en_w_d, clr_w_d, en_o_d, clr_o_d, ld_o_d, sh_o_d;
    logic [IWIDTH-1:0] ifm_d;
    logic [IWIDTH-1:0] wght_d;
    logic [OWIDTH-1:0] ofm_d;
    logic              ovf;
    // Local accumulator, visible for debug only.
    logic [OWIDTH-1:0] acc;

    modport master (
        output mode, sgn, en_i, clr_i, en_w, clr_w, en_o, clr_o, ld_o, sh_o, ifm, wght, ofm,
        input  en_i_d, clr_i_d, en_w_d, clr_w_d, en_o_d, clr_o_d, ld_o_d, sh_o_d,
        input  ifm_d, wght_d, ofm_d, ovf, acc
    );

    modport slave (
        input  mode, sgn, en_i, clr_i, en_w, clr_w, en_o, clr_o, ld_o, sh_o, ifm, wght, ofm,
        output en_i_d, clr_i_d, en_w_d, clr_w_d, en_o_d, clr_o_d, ld_o_d, sh_o_d,
        output ifm_d, wght_d, ofm_d, ovf, acc
    );
endinterface

// File: rtl/pe_border_os.sv
// Border PE with weight-stationary pass-through and output-stationary accumulate/unload modes,
// signed/unsigned operands, optional saturation and a sticky overflow flag.
module pe_border_os #(
    parameter int IWIDTH = 8,
    parameter int OWIDTH = 24,
    parameter int SAT    = 1
) (
    input  logic           clk,
    input  logic           rst,
    pe_border_os_if.slave  bus
);
    localparam int PW = 2 * IWIDTH + 1;
    localparam int MW = 2 * IWIDTH + 2;
    localparam int SW = OWIDTH + 2;

    if (OWIDTH < PW) begin : g_width_check
        $error("pe_border_os: OWIDTH must be at least 2*IWIDTH+1");
    end

    logic [IWIDTH-1:0] ifm_q, ifm_d;
    logic [IWIDTH-1:0] wght_q, wght_d;
    logic [OWIDTH-1:0] ofm_q, ofm_d;
    logic [OWIDTH-1:0] acc_q, acc_d;
    logic              ovf_q, ovf_d;
    logic [7:0]        ctl_q, ctl_d;

    logic signed [MW-1:0] a_w, b_w, prod_full;
    logic [PW-1:0]        prod;
    logic [OWIDTH-1:0]    base, prod_o, sat_res, lo_bound, hi_bound;
    logic [SW-1:0]        base_x, prod_x, sum;
    logic                 oor, under, commit;

    always_comb begin
        ifm_d = ifm_q;
        if (bus.clr_i)     ifm_d = '0;
        else if (bus.en_i) ifm_d = bus.ifm;

        wght_d = wght_q;
        if (bus.clr_w)     wght_d = '0;
        else if (bus.en_w) wght_d = bus.wght;

        ctl_d = {bus.en_i, bus.clr_i, bus.en_w, bus.clr_w, bus.en_o, bus.clr_o, bus.ld_o, bus.sh_o};

        // Extend both operands to the full product width so the multiply is self-sized.
        a_w       = {{(IWIDTH + 2){bus.sgn & ifm_q[IWIDTH-1]}}, ifm_q};
        b_w       = {{(IWIDTH + 2){bus.sgn & wght_q[IWIDTH-1]}}, wght_q};
        prod_full = a_w * b_w;
        prod      = prod_full[PW-1:0];
        prod_o    = {{(OWIDTH - PW){bus.sgn & prod[PW-1]}}, prod};

        base   = bus.mode ? acc_q : bus.ofm;
        base_x = {{2{bus.sgn & base[OWIDTH-1]}}, base};
        prod_x = {{(SW - PW){prod[PW-1]}}, prod};
        sum    = base_x + prod_x;
        under  = sum[SW-1];

        // Two guard bits: the sum is in range when they agree with the result's top bit (signed) or are zero (unsigned).
        if (bus.sgn) begin
            oor      = (sum[SW-1:OWIDTH-1] != '0) && (sum[SW-1:OWIDTH-1] != '1);
            lo_bound = {1'b1, {(OWIDTH - 1){1'b0}}};
            hi_bound = {1'b0, {(OWIDTH - 1){1'b1}}};
        end else begin
            oor      = (sum[SW-1:OWIDTH] != '0);
            lo_bound = '0;
            hi_bound = '1;
        end
        sat_res = ((SAT != 0) && oor) ? (under ? lo_bound : hi_bound) : sum[OWIDTH-1:0];

        ofm_d  = ofm_q;
        acc_d  = acc_q;
        commit = 1'b0;
        if (!bus.mode) begin
            if (bus.clr_o) begin
                ofm_d = '0;
            end else if (bus.en_o) begin
                ofm_d  = sat_res;
                commit = 1'b1;
            end
        end else begin
            if (bus.clr_o) begin
                acc_d = '0;
                ofm_d = '0;
            end else if (bus.ld_o) begin
                // Restart keeps this cycle's product so accumulation can overlap the unload.
                ofm_d = acc_q;
                acc_d = bus.en_o ? prod_o : '0;
            end else begin
                if (bus.en_o) begin
                    acc_d  = sat_res;
                    commit = 1'b1;
                end
                if (bus.sh_o) ofm_d = bus.ofm;
            end
        end

        ovf_d = bus.clr_o ? 1'b0 : (ovf_q | (commit & oor));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ifm_q  <= '0;
            wght_q <= '0;
            ofm_q  <= '0;
            acc_q  <= '0;
            ovf_q  <= 1'b0;
            ctl_q  <= '0;
        end else begin
            ifm_q  <= ifm_d;
            wght_q <= wght_d;
            ofm_q  <= ofm_d;
            acc_q  <= acc_d;
            ovf_q  <= ovf_d;
            ctl_q  <= ctl_d;
        end
    end

    assign bus.ifm_d   = ifm_q;
    assign bus.wght_d  = wght_q;
    assign bus.ofm_d   = ofm_q;
    assign bus.acc     = acc_q;
    assign bus.ovf     = ovf_q;
    assign bus.en_i_d  = ctl_q[7];
    assign bus.clr_i_d = ctl_q[6];
    assign bus.en_w_d  = ctl_q[5];
    assign bus.clr_w_d = ctl_q[4];
    assign bus.en_o_d  = ctl_q[3];
    assign bus.clr_o_d = ctl_q[2];
    assign bus.ld_o_d  = ctl_q[1];
    assign bus.sh_o_d  = ctl_q[0];
endmodule

// File: tb/tb_pe_border_os.sv
// Bench for pe_border_os: a saturating and a wrapping instance share one stimulus stream
// and are compared every cycle against an integer-arithmetic reference model.
module tb_pe_border_os;
    localparam int IW = 8;
    localparam int OW = 24;

    localparam logic [7:0] EI = 8'h80, CI = 8'h40, EW = 8'h20, CW = 8'h10;
    localparam logic [7:0] EO = 8'h08, CO = 8'h04, LD = 8'h02, SH = 8'h01;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          mode = 1'b0, sgn = 1'b0;
    logic [7:0]    ctl = '0;
    logic [IW-1:0] ifm = '0, wght = '0;
    logic [OW-1:0] ofm_in = '0;

    int checks = 0;
    int fails  = 0;

    // Reference state: index 0 = saturating instance, 1 = wrapping instance.
    logic [IW-1:0] m_ifm, m_wght;
    logic [OW-1:0] m_ofm[2], m_acc[2];
    logic          m_ovf[2];
    logic [7:0]    m_ctl;

    pe_border_os_if #(.IWIDTH(IW), .OWIDTH(OW)) bus_s ();
    pe_border_os_if #(.IWIDTH(IW), .OWIDTH(OW)) bus_w ();

    pe_border_os #(.IWIDTH(IW), .OWIDTH(OW), .SAT(1)) dut_s (.clk(clk), .rst(rst), .bus(bus_s));
    pe_border_os #(.IWIDTH(IW), .OWIDTH(OW), .SAT(0)) dut_w (.clk(clk), .rst(rst), .bus(bus_w));

    assign {bus_s.en_i, bus_s.clr_i, bus_s.en_w, bus_s.clr_w, bus_s.en_o, bus_s.clr_o, bus_s.ld_o, bus_s.sh_o} = ctl;
    assign {bus_w.en_i, bus_w.clr_i, bus_w.en_w, bus_w.clr_w, bus_w.en_o, bus_w.clr_o, bus_w.ld_o, bus_w.sh_o} = ctl;
    assign bus_s.mode = mode;
    assign bus_w.mode = mode;
    assign bus_s.sgn  = sgn;
    assign bus_w.sgn  = sgn;
    assign bus_s.ifm  = ifm;
    assign bus_w.ifm  = ifm;
    assign bus_s.wght = wght;
    assign bus_w.wght = wght;
    assign bus_s.ofm  = ofm_in;
    assign bus_w.ofm  = ofm_in;

    always #5 clk = ~clk;

    function automatic longint to_val(longint x, int w, bit s);
        longint v;
        v = x & ((longint'(1) << w) - 1);
        if (s && v[w-1]) v = v - (longint'(1) << w);
        return v;
    endfunction

    // Applies the accumulation rule to an exact integer sum.
    task automatic apply_sum(input longint s, input bit sat, input bit sg,
                             output logic [OW-1:0] r, output bit out_of_range);
        longint lo, hi, res;
        lo = sg ? -(longint'(1) << (OW - 1)) : 0;
        hi = sg ? (longint'(1) << (OW - 1)) - 1 : (longint'(1) << OW) - 1;
        out_of_range = (s < lo) || (s > hi);
        res = s;
        if (sat && s < lo) res = lo;
        if (sat && s > hi) res = hi;
        r = res[OW-1:0];
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d (0x%0h), expected %0d (0x%0h) at %0t", tag, obs, obs, exp, exp, $time);
        end
    endtask

    task automatic step();
        longint p, s;
        logic [OW-1:0] r;
        bit o;
        logic [OW-1:0] n_ofm[2], n_acc[2];
        logic n_ovf[2];
        logic [IW-1:0] n_ifm, n_wght;

        p = to_val(longint'(m_ifm), IW, sgn) * to_val(longint'(m_wght), IW, sgn);
        n_ifm  = ctl[6] ? '0 : (ctl[7] ? ifm : m_ifm);
        n_wght = ctl[4] ? '0 : (ctl[5] ? wght : m_wght);
        for (int k = 0; k < 2; k++) begin
            n_ofm[k] = m_ofm[k];
            n_acc[k] = m_acc[k];
            n_ovf[k] = m_ovf[k];
            if (ctl[2]) begin
                n_ofm[k] = '0;
                n_ovf[k] = 1'b0;
                if (mode) n_acc[k] = '0;
            end else if (!mode) begin
                if (ctl[3]) begin
                    s = to_val(longint'(ofm_in), OW, sgn) + p;
                    apply_sum(s, (k == 0), sgn, r, o);
                    n_ofm[k] = r;
                    n_ovf[k] = m_ovf[k] | o;
                end
            end else if (ctl[1]) begin
                n_ofm[k] = m_acc[k];
                n_acc[k] = ctl[3] ? p[OW-1:0] : '0;
            end else begin
                if (ctl[3]) begin
                    s = to_val(longint'(m_acc[k]), OW, sgn) + p;
                    apply_sum(s, (k == 0), sgn, r, o);
                    n_acc[k] = r;
                    n_ovf[k] = m_ovf[k] | o;
                end
                if (ctl[0]) n_ofm[k] = ofm_in;
            end
        end

        @(posedge clk);
        #1;
        if (rst) begin
            m_ifm = '0; m_wght = '0; m_ctl = '0;
            for (int k = 0; k < 2; k++) begin
                m_ofm[k] = '0; m_acc[k] = '0; m_ovf[k] = 1'b0;
            end
        end else begin
            m_ifm = n_ifm; m_wght = n_wght; m_ctl = ctl;
            for (int k = 0; k < 2; k++) begin
                m_ofm[k] = n_ofm[k]; m_acc[k] = n_acc[k]; m_ovf[k] = n_ovf[k];
            end
        end

        chk("ifm_d", 32'(bus_s.ifm_d), 32'(m_ifm));
        chk("wght_d", 32'(bus_s.wght_d), 32'(m_wght));
        chk("ctl_d", 32'({bus_s.en_i_d, bus_s.clr_i_d, bus_s.en_w_d, bus_s.clr_w_d,
                          bus_s.en_o_d, bus_s.clr_o_d, bus_s.ld_o_d, bus_s.sh_o_d}), 32'(m_ctl));
        chk("sat_ofm_d", 32'(bus_s.ofm_d), 32'(m_ofm[0]));
        chk("sat_acc", 32'(bus_s.acc), 32'(m_acc[0]));
        chk("sat_ovf", 32'(bus_s.ovf), 32'(m_ovf[0]));
        chk("wrap_ofm_d", 32'(bus_w.ofm_d), 32'(m_ofm[1]));
        chk("wrap_acc", 32'(bus_w.acc), 32'(m_acc[1]));
        chk("wrap_ovf", 32'(bus_w.ovf), 32'(m_ovf[1]));
    endtask

    task automatic drive(input logic [7:0] c, input logic [IW-1:0] i, input logic [IW-1:0] w,
                         input logic [OW-1:0] o);
        ctl = c; ifm = i; wght = w; ofm_in = o;
        step();
    endtask

    initial begin
        m_ifm = '0; m_wght = '0; m_ctl = '0;
        for (int k = 0; k < 2; k++) begin
            m_ofm[k] = '0; m_acc[k] = '0; m_ovf[k] = 1'b0;
        end

        // Reset with every input busy.
        mode = 1'b1; sgn = 1'b1; rst = 1'b1;
        drive(8'hFF, 8'h5A, 8'hA5, 24'h123456);
        chk("rst_ifm_d", 32'(bus_s.ifm_d), 0);
        chk("rst_ofm_d", 32'(bus_s.ofm_d), 0);
        chk("rst_ctl_ld_o_d", 32'(bus_s.ld_o_d), 0);
        chk("rst_ovf", 32'(bus_s.ovf), 0);
        rst = 1'b0;
        mode = 1'b0;
        drive(8'h00, 0, 0, 0);

        // WS signed: (-3)*5 + 100.
        drive(EI | EW, 8'hFD, 8'd5, 0);
        chk("ws_ifm_d", 32'(bus_s.ifm_d), 32'h0000_00FD);
        drive(EO, 0, 0, 24'd100);
        chk("ws_ofm_d_85", 32'(bus_s.ofm_d), 85);
        chk("ws_en_o_d_high", 32'(bus_s.en_o_d), 1);
        drive(8'h00, 0, 0, 0);
        chk("ws_en_o_d_low", 32'(bus_s.en_o_d), 0);
        chk("ws_ofm_d_hold", 32'(bus_s.ofm_d), 85);

        // OS accumulate 4*4 + 2*(-7) + 1*1, then load and shift.
        mode = 1'b1;
        drive(CO, 0, 0, 0);
        drive(EI | EW, 8'd4, 8'd4, 0);
        drive(EI | EW | EO, 8'd2, 8'hF9, 0);
        drive(EI | EW | EO, 8'd1, 8'd1, 0);
        drive(EI | EW | EO, 8'd10, 8'd1, 0);
        chk("os_acc_3", 32'(bus_s.acc), 3);
        drive(LD | EO, 0, 0, 0);
        chk("os_ld_ofm_d", 32'(bus_s.ofm_d), 3);
        chk("os_ld_acc", 32'(bus_s.acc), 10);
        drive(SH, 0, 0, 24'd77);
        chk("os_sh_ofm_d", 32'(bus_s.ofm_d), 77);

        // Signed saturation.
        mode = 1'b0;
        drive(CO | EI | EW, 8'd127, 8'd127, 0);
        drive(EO, 0, 0, 24'd8388600);
        chk("sat_pos_ofm_d", 32'(bus_s.ofm_d), 8388607);
        chk("sat_pos_ovf", 32'(bus_s.ovf), 1);
        drive(CO, 0, 0, 0);
        chk("sat_clr_ofm_d", 32'(bus_s.ofm_d), 0);
        chk("sat_clr_ovf", 32'(bus_s.ovf), 0);

        // Unsigned wrap.
        sgn = 1'b0;
        drive(EI | EW, 8'd255, 8'd255, 0);
        drive(EO, 0, 0, 24'hFFFFFF);
        chk("wrap_ofm_d_65024", 32'(bus_w.ofm_d), 65024);
        chk("wrap_ovf_set", 32'(bus_w.ovf), 1);
        chk("usat_ofm_d_max", 32'(bus_s.ofm_d), 32'h00FF_FFFF);

        // Priorities.
        mode = 1'b1;
        drive(8'h00, 0, 0, 0);
        drive(EO, 0, 0, 0);
        drive(CO | LD | EO | CI | EI, 8'd9, 0, 0);
        chk("prio_ofm_d", 32'(bus_s.ofm_d), 0);
        chk("prio_acc", 32'(bus_s.acc), 0);
        chk("prio_ifm_d", 32'(bus_s.ifm_d), 0);

        // Random segments across every mode/signedness pair.
        for (int seg = 0; seg < 4; seg++) begin
            mode = seg[0];
            sgn  = seg[1];
            drive(8'h00, 0, 0, 0);
            for (int n = 0; n < 150; n++) begin
                logic [7:0] c;
                logic [OW-1:0] o;
                c = '0;
                c[7] = ($urandom_range(0, 1) == 1);
                c[6] = ($urandom_range(0, 7) == 0);
                c[5] = ($urandom_range(0, 1) == 1);
                c[4] = ($urandom_range(0, 7) == 0);
                c[3] = ($urandom_range(0, 3) != 0);
                c[2] = ($urandom_range(0, 15) == 0);
                c[1] = ($urandom_range(0, 7) == 0);
                c[0] = ($urandom_range(0, 3) == 0);
                case ($urandom_range(0, 3))
                    0:       o = 24'h7FFF00 + 24'($urandom_range(0, 255));
                    1:       o = 24'hFFFF00 + 24'($urandom_range(0, 255));
                    2:       o = 24'h800000 + 24'($urandom_range(0, 255));
                    default: o = 24'($urandom);
                endcase
                rst = ($urandom_range(0, 99) == 0);
                drive(c, 8'($urandom), 8'($urandom), o);
                rst = 1'b0;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
